// File: rtl/cam_ctrl_top.sv
// Camera front-end: SCCB power-up/config sequencer (clk domain) and RGB565 byte-pair capture (cmos_pclk domain).
// Optional macro CAM_TEST_PATTERN_EN appends the colour-bar write (503D=80) to the register table.
module cam_ctrl_top #(
  parameter int         SCL_DIV  = 68,
  parameter int         RST_DLY  = 27000,
  parameter int         INIT_DLY = 540000,
  parameter int         GAP_DLY  = 27000,
  parameter logic [7:0] DEV_ADDR = 8'h78
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_pclk,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  output logic        cmos_rst_n,
  output logic        cmos_pwdn,
  output logic        cmos_scl,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_out_en,
  output logic        cam_init_done,
  output logic        half_cmos_clk,
  output logic        vsync,
  output logic        de,
  output logic [15:0] data_bgr565,
  output logic [23:0] data_bgr888,
  output logic [2:0]  cfg_state_o
);

`ifdef CAM_TEST_PATTERN_EN
  localparam int NUM_REGS = 7;
`else
  localparam int NUM_REGS = 6;
`endif
  localparam int CNT_W = $clog2(RST_DLY + INIT_DLY + GAP_DLY + SCL_DIV + 1);

  typedef enum logic [2:0] {
    S_PWR_RST, S_PWR_WAIT, S_START, S_SEND, S_STOP, S_GAP, S_DONE
  } cfg_state_e;

  function automatic logic [23:0] reg_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_entry = 24'h3103_11;
      3'd1:    reg_entry = 24'h3008_82;
      3'd2:    reg_entry = 24'h3008_42;
      3'd3:    reg_entry = 24'h4300_61;
      3'd4:    reg_entry = 24'h501F_01;
      3'd5:    reg_entry = 24'h3008_02;
      default: reg_entry = 24'h503D_80;
    endcase
  endfunction

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [2:0]       entry_q, entry_d;
  logic             scl_q, scl_d, sda_q, sda_d, sda_en_q, sda_en_d;
  logic             cmos_rst_n_q, done_q;
  logic             q_end;
  logic [23:0]      entry_w;
  logic [7:0]       cur_byte, byte_sh;
  logic             unused_sda;

  // ACK is never evaluated; the pin is only observed.
  assign unused_sda = sda_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWR_RST;
      cnt_q        <= '0;
      qtr_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      entry_q      <= '0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      sda_en_q     <= 1'b0;
      cmos_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      qtr_q        <= qtr_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      entry_q      <= entry_d;
      scl_q        <= scl_d;
      sda_q        <= sda_d;
      sda_en_q     <= sda_en_d;
      cmos_rst_n_q <= (state_d != S_PWR_RST);
      done_q       <= done_q | (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    entry_d = entry_q;
    q_end   = (cnt_q == CNT_W'(SCL_DIV - 1));
    // Bus states advance in quarter-bit steps; qtr wraps 3->0 at each bit boundary.
    if ((state_q == S_START || state_q == S_SEND || state_q == S_STOP) && q_end) begin
      cnt_d = '0;
      qtr_d = qtr_q + 1'b1;
    end
    case (state_q)
      S_PWR_RST:  if (cnt_q == CNT_W'(RST_DLY - 1)) begin
                    state_d = S_PWR_WAIT;
                    cnt_d   = '0;
                  end
      S_PWR_WAIT: if (cnt_q == CNT_W'(INIT_DLY - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    qtr_d   = '0;
                  end
      S_START:    if (q_end && qtr_q == 2'd3) begin
                    state_d = S_SEND;
                    bit_d   = '0;
                    byte_d  = '0;
                  end
      S_SEND:     if (q_end && qtr_q == 2'd3) begin
                    if (bit_q == 4'd8) begin
                      bit_d = '0;
                      if (byte_q == 2'd3) state_d = S_STOP;
                      else                byte_d  = byte_q + 1'b1;
                    end else begin
                      bit_d = bit_q + 1'b1;
                    end
                  end
      S_STOP:     if (q_end && qtr_q == 2'd3) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                  end
      S_GAP:      if (cnt_q == CNT_W'(GAP_DLY - 1)) begin
                    cnt_d = '0;
                    qtr_d = '0;
                    if (entry_q == 3'(NUM_REGS - 1)) begin
                      state_d = S_DONE;
                    end else begin
                      entry_d = entry_q + 1'b1;
                      state_d = S_START;
                    end
                  end
      default:    cnt_d = cnt_q;
    endcase
  end

  // Pin decode; SDA only moves in quarter 0 (SCL low) except inside START/STOP.
  always_comb begin
    entry_w = reg_entry(entry_q);
    case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = entry_w[23:16];
      2'd2:    cur_byte = entry_w[15:8];
      default: cur_byte = entry_w[7:0];
    endcase
    byte_sh  = cur_byte << bit_q[2:0];
    scl_d    = 1'b1;
    sda_d    = 1'b1;
    sda_en_d = 1'b0;
    case (state_q)
      S_START: begin
        sda_en_d = 1'b1;
        scl_d    = (qtr_q != 2'd3);
        sda_d    = (qtr_q < 2'd2);
      end
      S_SEND: begin
        scl_d    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        sda_en_d = (bit_q != 4'd8);
        sda_d    = (bit_q == 4'd8) ? 1'b1 : byte_sh[7];
      end
      S_STOP: begin
        sda_en_d = 1'b1;
        scl_d    = (qtr_q != 2'd0);
        sda_d    = (qtr_q >= 2'd2);
      end
      default: ;
    endcase
  end

  assign cmos_rst_n    = cmos_rst_n_q;
  assign cmos_pwdn     = 1'b0;
  assign cmos_scl      = scl_q;
  assign sda_o         = sda_q;
  assign sda_out_en    = sda_en_q;
  assign cam_init_done = done_q;
  assign cfg_state_o   = state_q;

  logic        half_q, phase_q, pend_q, de_q;
  logic [1:0]  vs_q, init_sync_q;
  logic [7:0]  b0_q;
  logic [15:0] pix_q, d565_q;
  logic [23:0] d888_q;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;

  assign r5 = pix_q[15:11];
  assign g6 = pix_q[10:5];
  assign b5 = pix_q[4:0];

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      half_q      <= 1'b0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      de_q        <= 1'b0;
      vs_q        <= '0;
      init_sync_q <= '0;
      b0_q        <= '0;
      pix_q       <= '0;
      d565_q      <= '0;
      d888_q      <= '0;
    end else begin
      half_q      <= ~half_q;
      vs_q        <= {vs_q[0], cmos_vsync};
      init_sync_q <= {init_sync_q[0], done_q};
      phase_q     <= cmos_href ? ~phase_q : 1'b0;
      if (cmos_href && !phase_q) b0_q <= cmos_db;
      // Outputs move only as half_cmos_clk falls, so they are stable across its rise.
      if (half_q) begin
        de_q   <= pend_q & init_sync_q[1];
        d565_q <= pix_q;
        d888_q <= {b5, b5[4:2], g6, g6[5:4], r5, r5[4:2]};
        pend_q <= 1'b0;
      end
      if (cmos_href && phase_q) begin
        pix_q  <= {b0_q, cmos_db};
        pend_q <= 1'b1;
      end
    end
  end

  assign half_cmos_clk = half_q;
  assign vsync         = vs_q[1];
  assign de            = de_q;
  assign data_bgr565   = d565_q;
  assign data_bgr888   = d888_q;

endmodule

// File: tb/tb_cam_ctrl_top.sv
// Directed bench for cam_ctrl_top: SCCB frame decode against the register table, pixel assembly, reset behaviour.
`timescale 1ns/1ps
module tb_cam_ctrl_top;
  localparam int SCL_DIV  = 2;
  localparam int RST_DLY  = 10;
  localparam int INIT_DLY = 20;
  localparam int GAP_DLY  = 8;
`ifdef CAM_TEST_PATTERN_EN
  localparam int N_WR = 7;
`else
  localparam int N_WR = 6;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cmos_pclk = 1'b0;
  logic cmos_vsync = 1'b0, cmos_href = 1'b0;
  logic [7:0] cmos_db = 8'h00;
  logic cmos_rst_n, cmos_pwdn, cmos_scl, sda_i, sda_o, sda_out_en;
  logic cam_init_done, half_cmos_clk, vsync, de;
  logic [15:0] data_bgr565;
  logic [23:0] data_bgr888;
  logic [2:0]  cfg_state_o;
  logic        sda_line;

  assign sda_line = sda_out_en ? sda_o : 1'b1;
  assign sda_i    = sda_line;

  cam_ctrl_top #(.SCL_DIV(SCL_DIV), .RST_DLY(RST_DLY), .INIT_DLY(INIT_DLY),
                 .GAP_DLY(GAP_DLY), .DEV_ADDR(8'h78)) dut (
    .clk(clk), .rst_n(rst_n), .cmos_pclk(cmos_pclk), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_db(cmos_db), .cmos_rst_n(cmos_rst_n), .cmos_pwdn(cmos_pwdn),
    .cmos_scl(cmos_scl), .sda_i(sda_i), .sda_o(sda_o), .sda_out_en(sda_out_en),
    .cam_init_done(cam_init_done), .half_cmos_clk(half_cmos_clk), .vsync(vsync), .de(de),
    .data_bgr565(data_bgr565), .data_bgr888(data_bgr888), .cfg_state_o(cfg_state_o)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always #7 cmos_pclk = ~cmos_pclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$], got_q[$];
  logic [39:0] pix_exp_q[$], pix_got_q[$];
  logic [7:0]  line_buf[16];

  // SCCB bus monitor, sampled on the falling clk edge
  int cyc, rst_rise_cyc, start_cyc, last_stop_cyc, done_cyc;
  int mon_bits, mon_frames, mon_badlen, mon_viol;
  logic mon_scl_p, mon_sda_p, in_frame;
  logic [7:0] mon_sh, nb;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; rst_rise_cyc = -1; start_cyc = -1; last_stop_cyc = -1; done_cyc = -1;
        mon_bits = 0; mon_frames = 0; mon_badlen = 0; mon_viol = 0;
        mon_scl_p = 1'b1; mon_sda_p = 1'b1; in_frame = 1'b0; mon_sh = 8'h00;
        got_q.delete();
      end else begin
        cyc++;
        if (cmos_rst_n === 1'b1 && rst_rise_cyc < 0) rst_rise_cyc = cyc;
        if (cam_init_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (cmos_scl && mon_scl_p && mon_sda_p && !sda_line) begin
          in_frame = 1'b1; mon_bits = 0;
          if (start_cyc < 0) start_cyc = cyc;
        end else if (cmos_scl && mon_scl_p && !mon_sda_p && sda_line) begin
          // 36 data/ACK clocks plus the STOP condition's own SCL rise
          mon_frames++;
          if (mon_bits != 37) mon_badlen++;
          in_frame = 1'b0; last_stop_cyc = cyc;
        end else if (sda_line != mon_sda_p && cmos_scl != mon_scl_p) begin
          mon_viol++;
        end
        if (cmos_scl && !mon_scl_p && in_frame) begin
          if (mon_bits % 9 != 8) begin
            nb = {mon_sh[6:0], sda_line};
            mon_sh = nb;
            if (mon_bits % 9 == 7) got_q.push_back(nb);
          end
          mon_bits++;
        end
        mon_scl_p = cmos_scl; mon_sda_p = sda_line;
      end
    end
  end

  // pixel monitors
  int de_pclk_cnt = 0, de_rise_cnt = 0;
  logic de_prev = 1'b0;
  initial forever begin
    @(posedge half_cmos_clk); #1;
    if (de === 1'b1) pix_got_q.push_back({data_bgr565, data_bgr888});
  end
  initial forever begin
    @(negedge cmos_pclk);
    if (de === 1'b1) begin
      de_pclk_cnt++;
      if (!de_prev) de_rise_cnt++;
    end
    de_prev = (de === 1'b1);
  end

  // driver tasks
  task automatic drive_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cmos_pclk); cmos_href = 1'b1; cmos_db = line_buf[i];
    end
    @(negedge cmos_pclk); cmos_href = 1'b0; cmos_db = 8'h00;
    repeat (8) @(negedge cmos_pclk);
  endtask

  task automatic clear_pix();
    pix_got_q.delete(); pix_exp_q.delete(); de_pclk_cnt = 0; de_rise_cnt = 0;
  endtask

  task automatic fill_exp();
    logic [23:0] tbl[7];
    tbl = '{24'h310311, 24'h300882, 24'h300842, 24'h430061, 24'h501F01, 24'h300802, 24'h503D80};
    exp_q.delete();
    for (int i = 0; i < N_WR; i++) begin
      exp_q.push_back(8'h78); exp_q.push_back(tbl[i][23:16]);
      exp_q.push_back(tbl[i][15:8]); exp_q.push_back(tbl[i][7:0]);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (cam_init_done !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
    n_cmp++;
    if (cam_init_done !== 1'b1) begin
      n_bad++; $display("FAIL %s_done_timeout: cam_init_done=%b after %0d cycles, want 1", tag, cam_init_done, k);
    end
  endtask

  task automatic check_table(input string tag);
    fill_exp();
    n_cmp++;
    if (mon_frames != N_WR) begin n_bad++; $display("FAIL %s_frames: got %0d want %0d", tag, mon_frames, N_WR); end
    n_cmp++;
    if (mon_badlen != 0) begin n_bad++; $display("FAIL %s_frame_len: %0d bad frames, want 0", tag, mon_badlen); end
    n_cmp++;
    if (mon_viol != 0) begin n_bad++; $display("FAIL %s_sda_vs_scl: %0d violations, want 0", tag, mon_viol); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL %s_byte_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_pix(input string tag, input int rises);
    n_cmp++;
    if (pix_got_q.size() != pix_exp_q.size()) begin
      n_bad++; $display("FAIL %s_pix_count: got %0d want %0d", tag, pix_got_q.size(), pix_exp_q.size());
    end
    for (int i = 0; i < pix_exp_q.size() && i < pix_got_q.size(); i++) begin
      n_cmp++;
      if (pix_got_q[i] !== pix_exp_q[i]) begin
        n_bad++; $display("FAIL %s_pix%0d: got 565=%h 888=%h want 565=%h 888=%h", tag, i,
                          pix_got_q[i][39:24], pix_got_q[i][23:0], pix_exp_q[i][39:24], pix_exp_q[i][23:0]);
      end
    end
    n_cmp++;
    if (de_pclk_cnt != 2 * pix_exp_q.size()) begin
      n_bad++; $display("FAIL %s_de_width: got %0d pclk want %0d", tag, de_pclk_cnt, 2 * pix_exp_q.size());
    end
    n_cmp++;
    if (de_rise_cnt != rises) begin n_bad++; $display("FAIL %s_de_pulses: got %0d want %0d", tag, de_rise_cnt, rises); end
  endtask

  // test tasks
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (cmos_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cmos_rst_n: got %b want 0", cmos_rst_n); end
    n_cmp++; if (cmos_pwdn !== 1'b0) begin n_bad++; $display("FAIL reset_cmos_pwdn: got %b want 0", cmos_pwdn); end
    n_cmp++; if (cmos_scl !== 1'b1) begin n_bad++; $display("FAIL reset_scl: got %b want 1", cmos_scl); end
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL reset_sda_o: got %b want 1", sda_o); end
    n_cmp++; if (sda_out_en !== 1'b0) begin n_bad++; $display("FAIL reset_sda_out_en: got %b want 0", sda_out_en); end
    n_cmp++; if (cam_init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b want 0", cam_init_done); end
    n_cmp++; if (half_cmos_clk !== 1'b0) begin n_bad++; $display("FAIL reset_half_clk: got %b want 0", half_cmos_clk); end
    n_cmp++; if (vsync !== 1'b0) begin n_bad++; $display("FAIL reset_vsync: got %b want 0", vsync); end
    n_cmp++; if (de !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %b want 0", de); end
    n_cmp++;
    if (data_bgr565 !== 16'h0 || data_bgr888 !== 24'h0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h want 0000/000000", data_bgr565, data_bgr888);
    end
  endtask

  task automatic test_power_up();
    int k;
    @(negedge clk); rst_n = 1'b1;
    k = 0;
    while (start_cyc < 0 && k < 500) begin @(negedge clk); k++; end
    n_cmp++;
    if (rst_rise_cyc < RST_DLY || rst_rise_cyc > RST_DLY + 1) begin
      n_bad++; $display("FAIL pwr_rst_release: cycle %0d want %0d..%0d", rst_rise_cyc, RST_DLY, RST_DLY + 1);
    end
    n_cmp++;
    if (start_cyc < 0 || start_cyc - rst_rise_cyc < INIT_DLY || start_cyc - rst_rise_cyc > INIT_DLY + 10) begin
      n_bad++; $display("FAIL pwr_first_start: %0d cycles after release want %0d..%0d",
                        start_cyc - rst_rise_cyc, INIT_DLY, INIT_DLY + 10);
    end
  endtask

  task automatic test_pixels_before_init();
    clear_pix();
    line_buf[0] = 8'hF8; line_buf[1] = 8'h1F; line_buf[2] = 8'h12; line_buf[3] = 8'h34;
    drive_bytes(4);
    n_cmp++;
    if (cam_init_done !== 1'b0) begin n_bad++; $display("FAIL preinit_state: init_done=%b want 0", cam_init_done); end
    n_cmp++;
    if (de_pclk_cnt != 0 || pix_got_q.size() != 0) begin
      n_bad++; $display("FAIL preinit_de: got %0d de cycles want 0", de_pclk_cnt);
    end
  endtask

  task automatic test_config();
    wait_done("cfg");
    check_table("cfg");
    n_cmp++;
    if (done_cyc - last_stop_cyc < GAP_DLY || done_cyc - last_stop_cyc > GAP_DLY + 4 * SCL_DIV + 4) begin
      n_bad++; $display("FAIL cfg_done_delay: %0d cycles after STOP want %0d..%0d",
                        done_cyc - last_stop_cyc, GAP_DLY, GAP_DLY + 4 * SCL_DIV + 4);
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (cam_init_done !== 1'b1 || cmos_scl !== 1'b1 || sda_out_en !== 1'b0) begin
      n_bad++; $display("FAIL cfg_idle: done=%b scl=%b en=%b want 1 1 0", cam_init_done, cmos_scl, sda_out_en);
    end
  endtask

  task automatic test_single_pixel();
    repeat (6) @(negedge cmos_pclk);
    clear_pix();
    line_buf[0] = 8'hF8; line_buf[1] = 8'h1F;
    pix_exp_q.push_back({16'hF81F, 24'hFF00FF});
    drive_bytes(2);
    check_pix("single", 1);
  endtask

  task automatic test_back_to_back();
    clear_pix();
    line_buf[0] = 8'h12; line_buf[1] = 8'h34; line_buf[2] = 8'hFF; line_buf[3] = 8'hFF;
    line_buf[4] = 8'h00; line_buf[5] = 8'h00; line_buf[6] = 8'h07; line_buf[7] = 8'hE0;
    pix_exp_q.push_back({16'h1234, 24'hA54510});
    pix_exp_q.push_back({16'hFFFF, 24'hFFFFFF});
    pix_exp_q.push_back({16'h0000, 24'h000000});
    pix_exp_q.push_back({16'h07E0, 24'h00FF00});
    drive_bytes(8);
    check_pix("b2b", 1);
  endtask

  task automatic test_href_drop();
    clear_pix();
    line_buf[0] = 8'hAB;
    drive_bytes(1);
    n_cmp++;
    if (de_pclk_cnt != 0) begin n_bad++; $display("FAIL drop_no_de: got %0d de cycles want 0", de_pclk_cnt); end
    line_buf[0] = 8'h07; line_buf[1] = 8'hE0;
    pix_exp_q.push_back({16'h07E0, 24'h00FF00});
    drive_bytes(2);
    check_pix("drop_next", 1);
  endtask

  task automatic test_vsync();
    @(negedge cmos_pclk); cmos_vsync = 1'b1;
    @(posedge cmos_pclk); #1;
    n_cmp++; if (vsync !== 1'b0) begin n_bad++; $display("FAIL vsync_d1: got %b want 0", vsync); end
    @(posedge cmos_pclk); #1;
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL vsync_d2: got %b want 1", vsync); end
    @(negedge cmos_pclk); cmos_vsync = 1'b0;
    repeat (2) @(posedge cmos_pclk); #1;
    n_cmp++; if (vsync !== 1'b0) begin n_bad++; $display("FAIL vsync_fall: got %b want 0", vsync); end
  endtask

  task automatic test_reset_mid_write();
    int k;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    k = 0;
    while (mon_bits != 13 && k < 2000) begin @(negedge clk); k++; end
    n_cmp++;
    if (mon_bits != 13) begin n_bad++; $display("FAIL midrst_reach: bit count %0d want 13", mon_bits); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sda_out_en !== 1'b0 || sda_o !== 1'b1 || cmos_scl !== 1'b1 || cmos_rst_n !== 1'b0 || cam_init_done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: en=%b sda=%b scl=%b rst=%b done=%b want 0 1 1 0 0",
                        sda_out_en, sda_o, cmos_scl, cmos_rst_n, cam_init_done);
    end
    @(negedge clk); rst_n = 1'b1;
    wait_done("midrst");
    check_table("midrst");
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_pixels_before_init();
    test_config();
    test_single_pixel();
    test_back_to_back();
    test_href_drop();
    test_vsync();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
